// File: rtl/sdram_init_seq_pkg.sv
// Shared command encodings, FSM state type and helpers for the SDRAM
// power-up initialisation sequencer.
package sdram_init_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_MRS     = 4'b0000;

    // A10 high during PRECHARGE selects all banks.
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

    typedef enum logic [3:0] {
        IDLE,
        POWERUP,
        PRECHARGE,
        WAIT_RP,
        REFRESH,
        WAIT_RFC,
        LOAD_MODE,
        WAIT_MRD,
        DONE
    } init_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init_seq_wait_timer.sv
// Loadable down-counter shared by every wait in the init sequence; it
// stops at zero and flags it.
module init_wait_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_brd_clk,
    input  logic             i_brd_rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
        if (i_brd_rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP delay, PRECHARGE ALL, auto-refreshes and
// LOAD MODE, then hands the pins over by raising o_memory_initialized.
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int          T_POWERUP_CYC = 8000,
    parameter int          T_RP_CYC      = 2,
    parameter int          T_RFC_CYC     = 7,
    parameter int          T_MRD_CYC     = 2,
    parameter int          REFRESH_COUNT = 8,
    parameter logic [12:0] MODE_REG      = 13'h020
) (
    input  logic        i_brd_clk,
    input  logic        i_brd_rst,
    input  logic        i_pll_locked,
    output logic        o_cke,
    output logic        o_cs_n,
    output logic        o_ras_n,
    output logic        o_cas_n,
    output logic        o_we_n,
    output logic [1:0]  o_ba,
    output logic [12:0] o_addr,
    output logic        o_memory_initialized
);

    localparam int T_MAX = max_int(max_int(T_POWERUP_CYC, T_RP_CYC),
                                   max_int(T_RFC_CYC, T_MRD_CYC));
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int RW    = $clog2(REFRESH_COUNT + 1);

    init_state_e   state_q;
    logic [3:0]    cmd_q;
    logic          cke_q;
    logic          init_q;
    logic [1:0]    ba_q;
    logic [12:0]   addr_q;
    logic [RW-1:0] ref_cnt_q;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_zero;
    logic          more_refs;

    assign more_refs = (ref_cnt_q < RW'(REFRESH_COUNT));

    // The timer is loaded with T-1 on the edge that issues a command, so the
    // next command edge lands exactly T cycles later (T=1 means back-to-back).
    // NOTE: every output of an always_comb gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if (!i_pll_locked) begin
            timer_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_load = 1'b1;
                    timer_val  = TW'(T_POWERUP_CYC - 1);
                end
                POWERUP: begin
                    timer_load = timer_zero;
                    timer_val  = TW'(T_RP_CYC - 1);
                end
                PRECHARGE, WAIT_RP: begin
                    timer_load = timer_zero;
                    timer_val  = TW'(T_RFC_CYC - 1);
                end
                REFRESH, WAIT_RFC: begin
                    timer_load = timer_zero;
                    timer_val  = more_refs ? TW'(T_RFC_CYC - 1) : TW'(T_MRD_CYC - 1);
                end
                default: ;
            endcase
        end
    end

    init_wait_timer #(.WIDTH(TW)) u_timer (
        .i_brd_clk (i_brd_clk),
        .i_brd_rst (i_brd_rst),
        .load_i    (timer_load),
        .value_i   (timer_val),
        .zero_o    (timer_zero)
    );

    always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
        if (i_brd_rst) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_INHIBIT;
            cke_q     <= 1'b0;
            init_q    <= 1'b0;
            ba_q      <= '0;
            addr_q    <= '0;
            ref_cnt_q <= '0;
        end else begin
            cmd_q  <= CMD_NOP;
            ba_q   <= '0;
            addr_q <= '0;
            if (!i_pll_locked) begin
                state_q   <= IDLE;
                cmd_q     <= CMD_INHIBIT;
                cke_q     <= 1'b0;
                init_q    <= 1'b0;
                ref_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= POWERUP;
                        cke_q     <= 1'b1;
                        ref_cnt_q <= '0;
                    end
                    POWERUP: begin
                        if (timer_zero) begin
                            state_q <= PRECHARGE;
                            cmd_q   <= CMD_PRE;
                            addr_q  <= PRE_ALL_ADDR;
                        end
                    end
                    PRECHARGE, WAIT_RP: begin
                        if (timer_zero) begin
                            state_q   <= REFRESH;
                            cmd_q     <= CMD_REF;
                            ref_cnt_q <= ref_cnt_q + RW'(1);
                        end else begin
                            state_q <= WAIT_RP;
                        end
                    end
                    REFRESH, WAIT_RFC: begin
                        if (timer_zero && more_refs) begin
                            state_q   <= REFRESH;
                            cmd_q     <= CMD_REF;
                            ref_cnt_q <= ref_cnt_q + RW'(1);
                        end else if (timer_zero) begin
                            state_q <= LOAD_MODE;
                            cmd_q   <= CMD_MRS;
                            addr_q  <= MODE_REG;
                        end else begin
                            state_q <= WAIT_RFC;
                        end
                    end
                    LOAD_MODE, WAIT_MRD: begin
                        if (timer_zero) begin
                            state_q <= DONE;
                            init_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT_MRD;
                        end
                    end
                    DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_cke                = cke_q;
    assign o_cs_n               = cmd_q[3];
    assign o_ras_n              = cmd_q[2];
    assign o_cas_n              = cmd_q[1];
    assign o_we_n               = cmd_q[0];
    assign o_ba                 = ba_q;
    assign o_addr               = addr_q;
    assign o_memory_initialized = init_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench: a per-cycle schedule model pushes expected pin states,
// monitors pop and compare on the falling edge. Two parameter sets run together.
module tb_sdram_init_seq;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        cke;
        logic        init;
    } pins_t;

    localparam pins_t RST_PINS = '{cmd: 4'b1111, ba: 2'b00, addr: 13'h0, cke: 1'b0, init: 1'b0};

    logic clk;
    logic rst;
    logic lock;

    logic        cke0, cs0, ras0, cas0, we0, init0;
    logic [1:0]  ba0;
    logic [12:0] addr0;
    logic        cke1, cs1, ras1, cas1, we1, init1;
    logic [1:0]  ba1;
    logic [12:0] addr1;

    pins_t act0, act1;
    assign act0 = {cs0, ras0, cas0, we0, ba0, addr0, cke0, init0};
    assign act1 = {cs1, ras1, cas1, we1, ba1, addr1, cke1, init1};

    sdram_init_seq #(
        .T_POWERUP_CYC(20), .T_RP_CYC(2), .T_RFC_CYC(7), .T_MRD_CYC(2),
        .REFRESH_COUNT(2), .MODE_REG(13'h020)
    ) dut0 (
        .i_brd_clk(clk), .i_brd_rst(rst), .i_pll_locked(lock),
        .o_cke(cke0), .o_cs_n(cs0), .o_ras_n(ras0), .o_cas_n(cas0), .o_we_n(we0),
        .o_ba(ba0), .o_addr(addr0), .o_memory_initialized(init0)
    );

    sdram_init_seq #(
        .T_POWERUP_CYC(20), .T_RP_CYC(2), .T_RFC_CYC(1), .T_MRD_CYC(2),
        .REFRESH_COUNT(1), .MODE_REG(13'h020)
    ) dut1 (
        .i_brd_clk(clk), .i_brd_rst(rst), .i_pll_locked(lock),
        .o_cke(cke1), .o_cs_n(cs1), .o_ras_n(ras1), .o_cas_n(cas1), .o_we_n(we1),
        .o_ba(ba1), .o_addr(addr1), .o_memory_initialized(init1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input pins_t got, input pins_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got cmd=%b ba=%0d addr=%h cke=%b init=%b exp cmd=%b ba=%0d addr=%h cke=%b init=%b",
                     name, $time, got.cmd, got.ba, got.addr, got.cke, got.init,
                     exp.cmd, exp.ba, exp.addr, exp.cke, exp.init);
        end
    endtask

    // Expected pins k cycles after POWERUP entry, straight from the command schedule.
    function automatic pins_t model_at(input int k, input int pu, input int rp,
                                       input int rfc, input int mrd, input int rc);
        pins_t e;
        int ref0, mrs;
        e    = '{cmd: 4'b0111, ba: 2'b00, addr: 13'h0, cke: 1'b1, init: 1'b0};
        ref0 = pu + rp;
        mrs  = ref0 + rc * rfc;
        if (k == pu) begin
            e.cmd  = 4'b0010;
            e.addr = 13'h0400;
        end else if (k >= ref0 && k < mrs && ((k - ref0) % rfc) == 0) begin
            e.cmd = 4'b0001;
        end else if (k == mrs) begin
            e.cmd  = 4'b0000;
            e.addr = 13'h020;
        end
        e.init = (k >= mrs + mrd);
        return e;
    endfunction

    pins_t q0[$];
    pins_t q1[$];
    int    k0, k1;
    bit    run0, run1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst || !lock) begin
            run0 = 1'b0;
            run1 = 1'b0;
            q0.push_back(RST_PINS);
            q1.push_back(RST_PINS);
        end else begin
            if (!run0) begin run0 = 1'b1; k0 = 0; end else k0++;
            if (!run1) begin run1 = 1'b1; k1 = 0; end else k1++;
            q0.push_back(model_at(k0, 20, 2, 7, 2, 2));
            q1.push_back(model_at(k1, 20, 2, 1, 2, 1));
        end
    end

    always @(negedge clk) begin
        if (q0.size() == 0) check("dut0_underflow", act0, ~act0);
        else check("dut0_cycle", act0, q0.pop_front());
        if (q1.size() == 0) check("dut1_underflow", act1, ~act1);
        else check("dut1_cycle", act1, q1.pop_front());
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        lock = 1'b1;
        wait_cycles(5);
        #2 rst = 1'b0;

        // Full run into DONE, then loss of lock in DONE and a full relock.
        wait_cycles(45);
        lock = 1'b0;
        wait_cycles(3);
        lock = 1'b1;
        wait_cycles(45);

        // Drop between refreshes, then relock through to DONE.
        lock = 1'b0;
        wait_cycles(2);
        lock = 1'b1;
        wait_cycles(26);
        lock = 1'b0;
        wait_cycles(3);
        lock = 1'b1;
        wait_cycles(45);

        // One-cycle lock glitch in IDLE.
        lock = 1'b0;
        wait_cycles(2);
        lock = 1'b1;
        wait_cycles(1);
        lock = 1'b0;
        wait_cycles(3);

        for (int i = 0; i < 8; i++) begin
            lock = 1'b1;
            n = int'($urandom_range(1, 45));
            wait_cycles(n);
            lock = 1'b0;
            n = int'($urandom_range(1, 3));
            wait_cycles(n);
        end

        // Asynchronous reset in the middle of the first refresh wait.
        lock = 1'b1;
        wait_cycles(26);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dut0", act0, RST_PINS);
        check("async_rst_dut1", act1, RST_PINS);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_cycles(45);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- SDRAM power-up initialisation sequencer on the board clock, directly upstream of the clocks/resets block.
- Waits for PLL lock, then holds NOPs through the power-up delay.
- Then issues PRECHARGE ALL, REFRESH_COUNT auto-refreshes and LOAD MODE REGISTER.
- On completion raises o_memory_initialized, which the clocks/resets block consumes to release SDRAM and system reset.
- Drives the SDRAM command pins only until done; the SDRAM controller takes the pins afterwards.

Parameters:
- T_POWERUP_CYC, 8000, NOP cycles after CKE rise (100 us at 80 MHz); must be >=1
- T_RP_CYC, 2, cycles from PRECHARGE to next command; must be >=1
- T_RFC_CYC, 7, cycles from REFRESH to next command; must be >=1
- T_MRD_CYC, 2, cycles from LOAD MODE to o_memory_initialized; must be >=1
- REFRESH_COUNT, 8, number of auto-refresh commands; must be >=1
- MODE_REG, 13'h020, value driven on o_addr during LOAD MODE (CL2, BL1, sequential)

Ports:
- i_brd_clk  in  1  board clock
- i_brd_rst  in  1  asynchronous active-high reset
- i_pll_locked  in  1  PLL lock, synchronous to i_brd_clk
- o_cke  out  1  SDRAM clock enable
- o_cs_n  out  1  chip select
- o_ras_n  out  1  row address strobe
- o_cas_n  out  1  column address strobe
- o_we_n  out  1  write enable
- o_ba  out  2  bank address
- o_addr  out  13  address / mode bits
- o_memory_initialized  out  1  init sequence complete

Interface decision: reset i_brd_rst, asynchronous, active-high; clock i_brd_clk.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_cke=0
  - o_cs_n=1, o_ras_n=1, o_cas_n=1, o_we_n=1 (INHIBIT)
  - o_ba=0, o_addr=0
  - o_memory_initialized=0
  - state IDLE, timer 0, refresh counter 0
- Command encodings {cs_n,ras_n,cas_n,we_n}:
  - INHIBIT 1111
  - NOP 0111
  - PRE 0010, with o_addr[10]=1 (all banks)
  - REF 0001
  - MRS 0000, with o_addr=MODE_REG, o_ba=0
- Every command is asserted for exactly one cycle; every non-command cycle after IDLE is NOP.
- FSM states and transitions:
  - IDLE: INHIBIT, cke=0. On i_pll_locked=1 go to POWERUP; o_cke=1 and NOP from the next cycle.
  - POWERUP: NOP for T_POWERUP_CYC cycles counted from the first POWERUP cycle. PRE is issued in cycle T_POWERUP_CYC (0-based) after POWERUP entry.
  - PRECHARGE (1 cycle) -> WAIT_RP: the next command is T_RP_CYC cycles after PRE.
  - REFRESH (1 cycle) -> WAIT_RFC: increment refresh count. If count < REFRESH_COUNT, issue the next REF T_RFC_CYC cycles later; otherwise issue MRS T_RFC_CYC cycles later.
  - LOAD_MODE (1 cycle) -> WAIT_MRD: o_memory_initialized goes to 1 T_MRD_CYC cycles after the MRS cycle.
  - DONE: o_memory_initialized=1, o_cke=1, NOP held on pins; remains until reset or loss of lock.
- Timing rule: spacing between consecutive commands equals the parameter exactly, never more.
- Timer: one down-counter, width $clog2(max(T_*)+1), loaded on each command. Refresh counter width $clog2(REFRESH_COUNT+1), no wrap.
- Boundary conditions:
  - i_pll_locked low in any state other than IDLE (including DONE): next cycle returns to IDLE with reset values on all outputs, including o_memory_initialized=0. The full sequence restarts on the next lock.
  - i_pll_locked glitch high for one cycle in IDLE still starts the sequence; a drop aborts as above.
  - i_brd_rst asserted mid-sequence: outputs take reset values immediately (asynchronously).
  - T_*=1: the next command is issued on the cycle directly after the previous one, with no NOP between.

Decomposition:
- Package sdram_init_pkg holds:
  - 4-bit command constants CMD_INHIBIT, CMD_NOP, CMD_PRE, CMD_REF, CMD_MRS
  - state enum IDLE, POWERUP, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC, LOAD_MODE, WAIT_MRD, DONE
- One sub-module is natural: init_wait_timer, a loadable down-counter with a zero flag, used for all waits.

Test Plan (bench params: T_POWERUP_CYC=20, T_RP_CYC=2, T_RFC_CYC=7, T_MRD_CYC=2, REFRESH_COUNT=2, MODE_REG=13'h020):
- Reset held, lock=1 -> INHIBIT, cke=0, initialized=0 throughout; after release, cke=1 one cycle after lock is sampled.
- Lock asserted, full run. Let P = POWERUP entry cycle +20, the PRE cycle:
  - PRE at P with addr[10]=1
  - REF at P+2 and P+9
  - MRS at P+16 with addr=13'h020, ba=0
  - o_memory_initialized rises at P+18 and stays high
  - all other cycles NOP
- Lock dropped at P+5 (between refreshes) -> next cycle INHIBIT, cke=0, no further commands; relock -> complete sequence repeats from POWERUP with identical spacing.
- Lock dropped in DONE -> o_memory_initialized falls next cycle; relock -> rises again after full sequence (P'+18).
- i_brd_rst pulsed asynchronously mid WAIT_RFC -> outputs reset without waiting for a clock edge; after release with lock high, sequence restarts from POWERUP.
- REFRESH_COUNT=1, T_RFC_CYC=1 -> exactly one REF, with MRS on the directly following cycle.
